// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, ALU-op encodings and control word for the MIPS pipeline control unit
package mips_ctrl_pkg;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] SLTI   = 6'h0A;

  // Encodings fit in 3 bits; the top zero-extends to ALUOP_W.
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_FUNC = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [2:0] alu_op;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '{default: '0};

endpackage

// File: rtl/mips_pipe_ctrl_if.sv
// rtl/mips_pipe_ctrl_if.sv - ID-stage inputs and ID/EX control outputs of the pipeline control unit
interface mips_pipe_ctrl_if #(
  parameter int OPC_W   = 6,
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 4,
  parameter int STAT_W  = 16
);
  logic               id_valid;
  logic [OPC_W-1:0]   id_opcode;
  logic [RA_W-1:0]    id_rs;
  logic [RA_W-1:0]    id_rt;
  logic               ex_flush;
  logic               ex_valid;
  logic               ex_reg_dst;
  logic               ex_branch;
  logic               ex_mem_read;
  logic               ex_mem_to_reg;
  logic               ex_mem_write;
  logic               ex_alu_src;
  logic               ex_reg_write;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [RA_W-1:0]    ex_rt;
  logic               ex_illegal;
  logic               stall;
  logic               pc_write;
  logic               ifid_write;
  logic [STAT_W-1:0]  stat_stalls;
  logic [STAT_W-1:0]  stat_flushes;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, ex_flush,
    input  ex_valid, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
           ex_alu_src, ex_reg_write, ex_alu_op, ex_rt, ex_illegal, stall, pc_write,
           ifid_write, stat_stalls, stat_flushes
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, ex_flush,
    output ex_valid, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
           ex_alu_src, ex_reg_write, ex_alu_op, ex_rt, ex_illegal, stall, pc_write,
           ifid_write, stat_stalls, stat_flushes
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational opcode decoder producing control word, uses_rt and illegal
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] i_opcode,
  output ctrl_word_t       o_ctrl,
  output logic             o_uses_rt,
  output logic             o_illegal
);

  always_comb begin
    o_ctrl    = CTRL_BUBBLE;
    o_uses_rt = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      OPC_W'(R_TYPE): begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALU_FUNC;
        o_uses_rt        = 1'b1;
      end
      OPC_W'(LW): begin
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.alu_op     = ALU_ADD;
      end
      OPC_W'(SW): begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = ALU_ADD;
        o_uses_rt        = 1'b1;
      end
      OPC_W'(BEQ): begin
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = ALU_SUB;
        o_uses_rt     = 1'b1;
      end
      OPC_W'(ADDI), OPC_W'(ANDI), OPC_W'(ORI), OPC_W'(SLTI): begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = (i_opcode == OPC_W'(ANDI)) ? ALU_AND :
                           (i_opcode == OPC_W'(ORI))  ? ALU_OR  :
                           (i_opcode == OPC_W'(SLTI)) ? ALU_SLT : ALU_ADD;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// rtl/mips_pipe_ctrl.sv - load-use hazard detection and ID/EX control register; MIPS_CTRL_STATS_EN adds stall/flush counters
module mips_pipe_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 4,
  parameter int STAT_W  = 16
) (
  input logic             clk,
  input logic             reset,
  mips_pipe_ctrl_if.slave bus
);

  ctrl_word_t       w_dec_ctrl;
  logic             w_uses_rt;
  logic             w_illegal;
  logic             w_stall;
  ctrl_word_t       r_ex_ctrl;
  logic             r_ex_valid;
  logic [RA_W-1:0]  r_ex_rt;
  logic             r_ex_illegal;

  mips_ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .i_opcode  (bus.id_opcode),
    .o_ctrl    (w_dec_ctrl),
    .o_uses_rt (w_uses_rt),
    .o_illegal (w_illegal)
  );

  // Gated by reset so the PC and IF/ID keep loading while the pipe is cleared.
  assign w_stall = ~reset & bus.id_valid & r_ex_valid & r_ex_ctrl.mem_read &
                   (r_ex_rt != '0) &
                   ((r_ex_rt == bus.id_rs) | (w_uses_rt & (r_ex_rt == bus.id_rt))) &
                   ~bus.ex_flush;

  always_ff @(posedge clk) begin
    if (reset || bus.ex_flush || w_stall) begin
      r_ex_ctrl    <= CTRL_BUBBLE;
      r_ex_valid   <= 1'b0;
      r_ex_rt      <= '0;
      r_ex_illegal <= 1'b0;
    end else if (bus.id_valid && !w_illegal) begin
      r_ex_ctrl    <= w_dec_ctrl;
      r_ex_valid   <= 1'b1;
      r_ex_rt      <= bus.id_rt;
      r_ex_illegal <= 1'b0;
    end else begin
      r_ex_ctrl    <= CTRL_BUBBLE;
      r_ex_valid   <= 1'b0;
      r_ex_rt      <= '0;
      r_ex_illegal <= bus.id_valid & w_illegal;
    end
  end

  assign bus.stall         = w_stall;
  assign bus.pc_write      = ~w_stall;
  assign bus.ifid_write    = ~w_stall;
  assign bus.ex_valid      = r_ex_valid;
  assign bus.ex_reg_dst    = r_ex_ctrl.reg_dst;
  assign bus.ex_branch     = r_ex_ctrl.branch;
  assign bus.ex_mem_read   = r_ex_ctrl.mem_read;
  assign bus.ex_mem_to_reg = r_ex_ctrl.mem_to_reg;
  assign bus.ex_mem_write  = r_ex_ctrl.mem_write;
  assign bus.ex_alu_src    = r_ex_ctrl.alu_src;
  assign bus.ex_reg_write  = r_ex_ctrl.reg_write;
  assign bus.ex_alu_op     = ALUOP_W'(r_ex_ctrl.alu_op);
  assign bus.ex_rt         = r_ex_rt;
  assign bus.ex_illegal    = r_ex_illegal;

`ifdef MIPS_CTRL_STATS_EN
  logic [STAT_W-1:0] r_stat_stalls;
  logic [STAT_W-1:0] r_stat_flushes;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_stalls  <= '0;
      r_stat_flushes <= '0;
    end else begin
      if (w_stall && (r_stat_stalls != '1))
        r_stat_stalls <= r_stat_stalls + 1'b1;
      if (bus.ex_flush && (r_stat_flushes != '1))
        r_stat_flushes <= r_stat_flushes + 1'b1;
    end
  end

  assign bus.stat_stalls  = r_stat_stalls;
  assign bus.stat_flushes = r_stat_flushes;
`else
  assign bus.stat_stalls  = {STAT_W{1'b0}};
  assign bus.stat_flushes = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// tb/tb_mips_pipe_ctrl.sv - directed self-checking bench for mips_pipe_ctrl
module tb_mips_pipe_ctrl;

`ifdef MIPS_CTRL_STATS_EN
  localparam int SW_ = 2;
`else
  localparam int SW_ = 16;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mips_pipe_ctrl_if #(.OPC_W(6), .RA_W(5), .ALUOP_W(4), .STAT_W(SW_)) bus ();

  mips_pipe_ctrl #(.OPC_W(6), .RA_W(5), .ALUOP_W(4), .STAT_W(SW_)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] opc, input logic [4:0] rs,
                       input logic [4:0] rt, input logic fl);
    bus.id_valid  = v;
    bus.id_opcode = opc;
    bus.id_rs     = rs;
    bus.id_rt     = rt;
    bus.ex_flush  = fl;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 6'h23, 5'd0, 5'd8, 1'b0);
    tick();
    tick();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL rst_ex_valid got=%b exp=0", bus.ex_valid); end
    total++; if (bus.ex_mem_read !== 1'b0) begin bad++; $display("FAIL rst_mem_read got=%b exp=0", bus.ex_mem_read); end
    total++; if (bus.ex_rt !== 5'd0) begin bad++; $display("FAIL rst_ex_rt got=%0d exp=0", bus.ex_rt); end
    total++; if (bus.stall !== 1'b0 || bus.pc_write !== 1'b1 || bus.ifid_write !== 1'b1) begin
      bad++; $display("FAIL rst_enables stall=%b pc=%b ifid=%b exp 0/1/1", bus.stall, bus.pc_write, bus.ifid_write); end
    reset = 1'b0;
    tick();
    total++; if (bus.ex_mem_read !== 1'b1 || bus.ex_alu_op !== 4'b0000 || bus.ex_valid !== 1'b1 || bus.ex_rt !== 5'd8) begin
      bad++; $display("FAIL first_lw mr=%b op=%b v=%b rt=%0d exp 1/0000/1/8", bus.ex_mem_read, bus.ex_alu_op, bus.ex_valid, bus.ex_rt); end
  endtask

  task automatic test_load_use();
    // ex already holds lw rt=8 from test_reset
    drive(1'b1, 6'h00, 5'd8, 5'd9, 1'b0);
    total++; if (bus.stall !== 1'b1 || bus.pc_write !== 1'b0) begin
      bad++; $display("FAIL lu_rs_stall stall=%b pc=%b exp 1/0", bus.stall, bus.pc_write); end
    tick();
    total++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0) begin
      bad++; $display("FAIL lu_bubble v=%b wr=%b exp 0/0", bus.ex_valid, bus.ex_reg_write); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_one_cycle stall=%b exp 0", bus.stall); end
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_reg_dst !== 1'b1 || bus.ex_alu_op !== 4'b0010 || bus.ex_rt !== 5'd9) begin
      bad++; $display("FAIL lu_add_issue v=%b dst=%b op=%b rt=%0d exp 1/1/0010/9", bus.ex_valid, bus.ex_reg_dst, bus.ex_alu_op, bus.ex_rt); end
    drive(1'b1, 6'h23, 5'd0, 5'd8, 1'b0);
    tick();
    drive(1'b1, 6'h00, 5'd3, 5'd8, 1'b0);
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL lu_rt_stall stall=%b exp 1", bus.stall); end
    tick();
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL lu_rt_bubble v=%b exp 0", bus.ex_valid); end
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_reg_write !== 1'b1) begin
      bad++; $display("FAIL lu_rt_issue v=%b wr=%b exp 1/1", bus.ex_valid, bus.ex_reg_write); end
    drive(1'b1, 6'h23, 5'd0, 5'd8, 1'b0);
    tick();
    drive(1'b1, 6'h08, 5'd3, 5'd8, 1'b0);
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_addi_nostall stall=%b exp 0", bus.stall); end
    tick();
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_alu_src !== 1'b1 || bus.ex_mem_read !== 1'b0) begin
      bad++; $display("FAIL lu_addi_issue v=%b src=%b mr=%b exp 1/1/0", bus.ex_valid, bus.ex_alu_src, bus.ex_mem_read); end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 6'h23, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 6'h00, 5'd0, 5'd0, 1'b0);
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL zero_reg stall=%b exp 0", bus.stall); end
    tick();
  endtask

  task automatic test_flush_priority();
    drive(1'b1, 6'h23, 5'd0, 5'd8, 1'b0);
    tick();
    drive(1'b1, 6'h00, 5'd8, 5'd1, 1'b1);
    total++; if (bus.stall !== 1'b0 || bus.pc_write !== 1'b1) begin
      bad++; $display("FAIL flush_stall stall=%b pc=%b exp 0/1", bus.stall, bus.pc_write); end
    tick();
    total++; if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_alu_op !== 4'd0) begin
      bad++; $display("FAIL flush_bubble v=%b wr=%b op=%b exp 0/0/0000", bus.ex_valid, bus.ex_reg_write, bus.ex_alu_op); end
    drive(1'b0, 6'h00, 5'd0, 5'd0, 1'b0);
    tick();
  endtask

  task automatic test_illegal();
    drive(1'b1, 6'h3F, 5'd1, 5'd2, 1'b0);
    tick();
    total++; if (bus.ex_illegal !== 1'b1 || bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 ||
                 bus.ex_mem_write !== 1'b0 || bus.ex_branch !== 1'b0) begin
      bad++; $display("FAIL illegal ill=%b v=%b wr=%b mw=%b br=%b exp 1/0/0/0/0", bus.ex_illegal, bus.ex_valid,
                      bus.ex_reg_write, bus.ex_mem_write, bus.ex_branch); end
    drive(1'b0, 6'h3F, 5'd1, 5'd2, 1'b0);
    tick();
    total++; if (bus.ex_illegal !== 1'b0) begin bad++; $display("FAIL illegal_pulse ill=%b exp 0", bus.ex_illegal); end
  endtask

  task automatic test_decode_table();
    logic [16:0] tbl [8];
    logic [10:0] got;
    // {opcode, dst, br, mr, m2r, mw, src, wr, alu_op}
    tbl[0] = {6'h00, 7'b1000001, 4'b0010};
    tbl[1] = {6'h23, 7'b0011011, 4'b0000};
    tbl[2] = {6'h2B, 7'b0000110, 4'b0000};
    tbl[3] = {6'h04, 7'b0100000, 4'b0001};
    tbl[4] = {6'h08, 7'b0000011, 4'b0000};
    tbl[5] = {6'h0C, 7'b0000011, 4'b0011};
    tbl[6] = {6'h0D, 7'b0000011, 4'b0100};
    tbl[7] = {6'h0A, 7'b0000011, 4'b0101};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i][16:11], 5'd0, 5'd0, 1'b0);
      tick();
      got = {bus.ex_reg_dst, bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_mem_write,
             bus.ex_alu_src, bus.ex_reg_write, bus.ex_alu_op};
      total++; if (got !== tbl[i][10:0] || bus.ex_valid !== 1'b1 || bus.ex_illegal !== 1'b0) begin
        bad++; $display("FAIL decode_%0h got=%b v=%b exp=%b v=1", tbl[i][16:11], got, bus.ex_valid, tbl[i][10:0]); end
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 6'h23, 5'd0, 5'd8, 1'b0);
    tick();
    drive(1'b1, 6'h00, 5'd8, 5'd1, 1'b0);
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL rms_pre stall=%b exp 1", bus.stall); end
    reset = 1'b1;
    #1;
    total++; if (bus.pc_write !== 1'b1 || bus.stall !== 1'b0) begin
      bad++; $display("FAIL rms_in_reset pc=%b stall=%b exp 1/0", bus.pc_write, bus.stall); end
    tick();
    reset = 1'b0;
    #1;
    total++; if (bus.stall !== 1'b0 || bus.ex_valid !== 1'b0) begin
      bad++; $display("FAIL rms_after stall=%b v=%b exp 0/0", bus.stall, bus.ex_valid); end
    tick();
  endtask

  task automatic test_stats();
    reset = 1'b1;
    drive(1'b0, 6'h00, 5'd0, 5'd0, 1'b0);
    tick();
    reset = 1'b0;
    total++; if (bus.stat_stalls !== '0) begin bad++; $display("FAIL stat_clear got=%0d exp 0", bus.stat_stalls); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 6'h23, 5'd0, 5'd8, 1'b0);
      tick();
      drive(1'b1, 6'h00, 5'd8, 5'd2, 1'b0);
      tick();
    end
    drive(1'b0, 6'h00, 5'd0, 5'd0, 1'b1);
    tick();
    drive(1'b0, 6'h00, 5'd0, 5'd0, 1'b0);
`ifdef MIPS_CTRL_STATS_EN
    total++; if (bus.stat_stalls !== 2'd3) begin bad++; $display("FAIL stat_sat got=%0d exp 3", bus.stat_stalls); end
    total++; if (bus.stat_flushes !== 2'd1) begin bad++; $display("FAIL stat_flush got=%0d exp 1", bus.stat_flushes); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (bus.stat_stalls !== 2'd0 || bus.stat_flushes !== 2'd0) begin
      bad++; $display("FAIL stat_reset st=%0d fl=%0d exp 0/0", bus.stat_stalls, bus.stat_flushes); end
`else
    total++; if (bus.stat_stalls !== '0 || bus.stat_flushes !== '0) begin
      bad++; $display("FAIL stat_tied st=%0d fl=%0d exp 0/0", bus.stat_stalls, bus.stat_flushes); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 6'h00, 5'd0, 5'd0, 1'b0);
    test_reset();
    test_load_use();
    test_zero_reg();
    test_flush_priority();
    test_illegal();
    test_decode_table();
    test_reset_mid_stall();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
